// File: rtl/vga_timing_sequencer_if.sv
// Renderer-facing request bus plus the delayed VGA pins of the timing sequencer.
// The master modport is the sequencer; the slave modport is the renderer/pad side.
interface vga_timing_sequencer_if;
    logic        req_valid;
    logic [10:0] req_x;
    logic [9:0]  req_y;
    logic        line_start;
    logic        frame_start;
    logic [23:0] rgb_in;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    modport master (
        output req_valid, req_x, req_y, line_start, frame_start,
        output vga_hsync, vga_vsync, vga_blank_n, vga_r, vga_g, vga_b,
        input  rgb_in
    );

    modport slave (
        input  req_valid, req_x, req_y, line_start, frame_start,
        input  vga_hsync, vga_vsync, vga_blank_n, vga_r, vga_g, vga_b,
        output rgb_in
    );
endinterface

// File: rtl/vga_timing_sequencer.sv
// VGA scan sequencer: h/v counters, pixel requests, sync/blank delayed to renderer latency.
// Latency: requests are registered counter-stage outputs; sync/blank lag them by PIPE_LAT cycles.
// No backpressure: scan-out starts/stops only at frame boundaries; FRAME_COUNTER_EN adds frame_cnt.
module vga_timing_sequencer #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        busy,
`ifdef FRAME_COUNTER_EN
    output logic [15:0] frame_cnt,
`endif
    vga_timing_sequencer_if.master bus
);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    // Pipeline carries "asserted" flags; conversion to pin polarity happens at the output.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } vid_t;

    state_t      state, state_nxt;
    logic [10:0] h, h_nxt;
    logic [9:0]  v, v_nxt;
    logic        req_valid, line_start, frame_start;
    logic        req_valid_nxt, line_start_nxt, frame_start_nxt;
    logic        last_h, last_frame, run_nxt;
    vid_t        raw;
    vid_t        pipe [PIPE_LAT];

    always_comb begin
        state_nxt  = state;
        h_nxt      = h;
        v_nxt      = v;
        last_h     = (h == H_LAST);
        last_frame = last_h && (v == V_LAST);

        if (state != IDLE) begin
            if (last_h) begin
                h_nxt = '0;
                v_nxt = (v == V_LAST) ? '0 : v + 10'd1;
            end else begin
                h_nxt = h + 11'd1;
            end
        end

        case (state)
            IDLE: begin
                h_nxt = '0;
                v_nxt = '0;
                if (en) state_nxt = RUN;
            end
            RUN: begin
                // Dropping EN on the very last pixel must not start another frame.
                if (!en) state_nxt = last_frame ? IDLE : STOPPING;
            end
            STOPPING: begin
                if (en)              state_nxt = RUN;
                else if (last_frame) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        run_nxt         = (state_nxt != IDLE);
        req_valid_nxt   = run_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);
        line_start_nxt  = run_nxt && (h_nxt == '0) && (v_nxt < V_ACT);
        frame_start_nxt = run_nxt && (h_nxt == '0) && (v_nxt == '0);

        raw.hs  = busy && (h >= HS_BEG) && (h < HS_END);
        raw.vs  = busy && (v >= VS_BEG) && (v < VS_END);
        raw.act = req_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            h           <= '0;
            v           <= '0;
            req_valid   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
        end else begin
            state       <= state_nxt;
            h           <= h_nxt;
            v           <= v_nxt;
            req_valid   <= req_valid_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
            pipe[0]     <= raw;
            for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

`ifdef FRAME_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst)                  frame_cnt <= '0;
        else if (frame_start_nxt) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

    assign busy            = (state != IDLE);
    assign bus.req_valid   = req_valid;
    assign bus.req_x       = h;
    assign bus.req_y       = v;
    assign bus.line_start  = line_start;
    assign bus.frame_start = frame_start;
    assign bus.vga_hsync   = pipe[PIPE_LAT-1].hs ? SYNC_POL : ~SYNC_POL;
    assign bus.vga_vsync   = pipe[PIPE_LAT-1].vs ? SYNC_POL : ~SYNC_POL;
    assign bus.vga_blank_n = pipe[PIPE_LAT-1].act;
    assign bus.vga_r       = pipe[PIPE_LAT-1].act ? bus.rgb_in[23:16] : 8'd0;
    assign bus.vga_g       = pipe[PIPE_LAT-1].act ? bus.rgb_in[15:8]  : 8'd0;
    assign bus.vga_b       = pipe[PIPE_LAT-1].act ? bus.rgb_in[7:0]   : 8'd0;
endmodule
